bsmul_seq: RTL
==============

Name: bsmul_seq

Overview:
Sequencer for the bit-serial multiplier datapath (serial operand a, parallel operand b, isync/osync framing). It accepts parallel operand pairs over a valid/ready handshake and latches b onto the multiplier's parallel input. It shifts a into the multiplier LSB-first with zero padding, raising isync on the first bit. It then deserialises the serial product into a 2*LEN-bit parallel result, returned over a second valid/ready handshake. It runs one operation at a time and has a timeout guard against a missing osync.

Parameters:
LEN, 5, operand width in bits; matches the multiplier's LEN.
RW, 2*LEN, result width and serial frame length in bits.
TIMEOUT, 4*LEN, maximum cycles from the isync cycle to osync before aborting.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept an operand pair.
in_a  input  LEN  serial-side operand.
in_b  input  LEN  parallel-side operand.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_q  output  RW  product, unsigned.
out_err  output  1  result aborted by timeout; qualified by out_valid.
busy  output  1  high in RUN and DONE.
mul_a  output  1  serial bit to the multiplier's a input.
mul_b  output  LEN  to the multiplier's b input.
mul_isync  output  1  frame start to the multiplier.
mul_q  input  1  serial product bit from the multiplier.
mul_osync  input  1  first-product-bit marker from the multiplier.

Behaviour:
- Reset (async, any state): state=IDLE; mul_a=0, mul_isync=0, mul_b=0, out_valid=0, out_q=0, out_err=0, busy=0. In-flight operation is discarded and no out_valid is produced. in_ready=1 from the first cycle after reset deassertion.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge k:
  - latch in_a and in_b; mul_b=in_b from cycle k+1;
  - clear tx/rx/timeout counters and out_err; go to RUN.
- RUN, tx engine: cycle k+1+i, i=0..RW-1:
  - mul_a=a[i] for i<LEN, mul_a=0 for LEN<=i<RW;
  - mul_isync=1 only at i=0.
  - After RW bits, mul_a=0 and mul_isync=0. mul_b holds until the next accept.
- RUN, rx engine: armed from cycle k+1, including that cycle.
  - First sampled mul_osync=1 marks mul_q as product bit 0, captured into bit 0.
  - Bits 1..RW-1 are captured on the following RW-1 consecutive cycles.
  - Further osync pulses during the operation are ignored.
  - osync in IDLE or DONE is ignored.
- RUN->DONE when tx has sent RW bits and rx has captured RW bits. out_valid=1 in the cycle after the last capture edge.
- Latency: with osync D cycles after the isync cycle (D>=0), out_valid asserts at cycle k+1+D+RW.
- Timeout: a counter starts on the isync cycle. If TIMEOUT cycles pass with no osync, go to DONE with out_err=1 and out_q=0. Once capture has started, the timeout is disabled.
- DONE: in_ready=0. out_valid, out_q and out_err stay stable until out_ready=1. On out_valid&out_ready, out_valid=0 and state=IDLE in the next cycle. No new accept happens in that same cycle.
- Back-to-back: the minimum gap between successive isync pulses is RW+D+2 cycles with out_ready tied high.
- Counters are $clog2(max(RW,TIMEOUT)+1) bits wide and do not wrap within an operation.
- No arithmetic in the sequencer; out_q is exactly the captured bit stream, LSB first.

Test Plan:
Bench uses a behavioural multiplier model with configurable osync delay D that emits the product LSB-first; LEN=5.
1. a=3, b=5, D=0, out_ready=1 -> mul_isync single pulse at k+1; mul_a sequence 1,1,0,0,0,0,0,0,0,0; out_q=15, out_err=0; out_valid at k+11.
2. a=31, b=31, D=3 -> out_q=961; out_valid at k+14; no more in_ready until the handshake completes.
3. a=7, b=9, out_ready held low 5 cycles after out_valid -> out_q=63 held stable; in_ready=0; busy=1; IDLE one cycle after out_ready rises.
4. Model never asserts osync -> out_valid at cycle k+1+20 with out_err=1 and out_q=0; next operation a=2, b=2, D=0 -> out_q=4, out_err=0.
5. Assert reset at cycle k+4 mid-RUN -> all outputs 0 immediately; no out_valid; after release, a=1, b=1 -> out_q=1.
6. Three back-to-back ops, in_valid high, out_ready=1, D=1: (0,31), (31,0), (1,31) -> out_q 0, 0, 31; isync pulses 13 cycles apart.

Source files
------------

// File: rtl/bsmul_seq.sv
// Sequencer for a bit-serial multiplier: shifts operand a out LSB-first and deserialises the product.
// Result valid 1+D+RW cycles after accept (D = isync->osync delay); one op in flight, in_ready low until the result is taken.
module bsmul_seq #(
  parameter int LEN     = 5,
  parameter int RW      = 2*LEN,
  parameter int TIMEOUT = 4*LEN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LEN-1:0] in_a,
  input  logic [LEN-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_q,
  output logic          out_err,
  output logic          busy,
  output logic          mul_a,
  output logic [LEN-1:0] mul_b,
  output logic          mul_isync,
  input  logic          mul_q,
  input  logic          mul_osync
);

  localparam int CMAX = (RW > TIMEOUT) ? RW : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [LEN-1:0] a_sh;
  logic [RW-1:0]  rx_sh;
  logic [CW-1:0]  tx_cnt;
  logic [CW-1:0]  rx_cnt;
  logic [CW-1:0]  to_cnt;

  logic accept;
  logic tx_go;
  logic tx_fin;
  logic rx_cap;
  logic rx_fin;
  logic to_tick;
  logic to_hit;

  assign accept = in_valid && in_ready;

  // tx_cnt counts bits already placed on mul_a; the accept edge places bit 0
  assign tx_go  = (state == RUN) && (tx_cnt < CW'(RW));
  assign tx_fin = (tx_cnt == CW'(RW)) || (tx_go && (tx_cnt == CW'(RW - 1)));

  // Capture opens on the first osync and then runs unconditionally for RW bits
  assign rx_cap = (state == RUN) && (rx_cnt < CW'(RW)) &&
                  ((rx_cnt != '0) || mul_osync);
  assign rx_fin = (rx_cnt == CW'(RW)) || (rx_cap && (rx_cnt == CW'(RW - 1)));

  assign to_tick = (state == RUN) && (rx_cnt == '0) && !mul_osync;
  assign to_hit  = to_tick && (to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (to_hit || (tx_fin && rx_fin)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = !reset;
      RUN:     busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh      <= '0;
      rx_sh     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      to_cnt    <= '0;
      mul_a     <= 1'b0;
      mul_b     <= '0;
      mul_isync <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      mul_isync <= accept;
      if (accept) begin
        mul_a   <= in_a[0];
        a_sh    <= in_a >> 1;
        mul_b   <= in_b;
        tx_cnt  <= CW'(1);
        rx_cnt  <= '0;
        to_cnt  <= '0;
        rx_sh   <= '0;
        out_err <= 1'b0;
      end else begin
        // a_sh drains to zero after LEN bits, which supplies the padding
        if (tx_go) begin
          mul_a  <= a_sh[0];
          a_sh   <= a_sh >> 1;
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          mul_a  <= 1'b0;
        end
        if (rx_cap) begin
          rx_sh  <= {mul_q, rx_sh[RW-1:1]};
          rx_cnt <= rx_cnt + CW'(1);
        end
        if (to_tick) begin
          to_cnt <= to_cnt + CW'(1);
        end
        if (to_hit) begin
          out_err <= 1'b1;
        end
      end
    end
  end

  // A timed-out op never captured a bit, so the cleared shifter reads as zero
  assign out_q = rx_sh;

endmodule
